branch_resolve_unit: RTL
========================

// Module: branch_resolve_unit
// PURPOSE
//  Parametrised, registered branch-decision unit for the multicycle CPU datapath.
//  Launched by the control unit with a start pulse; captures operands and evaluates one of eight conditions.
//  Computes the branch target and returns next-PC plus taken flag after a fixed 2-cycle latency.
//  Its pc_next output feeds the PC source mux.
// PARAMETERS
//  DATA_W   32  operand / address width
//  OFF_SH   2   left shift applied to sign-extended offset (word addressing)
//  CNT_W    16  width of statistics counters (used only with BRANCH_STATS_EN)
// PORTS
//  clk          in   1       system clock, rising edge
//  reset        in   1       synchronous, active-high reset
//  start        in   1       launch request; sampled only in IDLE or RES
//  branch_op    in   3       condition select, captured with start
//  rs_val       in   DATA_W  first operand
//  rt_val       in   DATA_W  second operand
//  pc_plus4     in   DATA_W  fall-through address
//  offset       in   DATA_W  sign-extended immediate
//  busy         out  1       high in CMP and RES
//  done         out  1       one-cycle pulse, pc_next/taken valid
//  taken        out  1       condition result of last resolved branch
//  pc_next      out  DATA_W  target if taken, else pc_plus4; held until next done
//  stat_total   out  CNT_W   branches resolved (BRANCH_STATS_EN only)
//  stat_taken   out  CNT_W   branches taken (BRANCH_STATS_EN only)
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, taken=0, pc_next=0, stat_* =0; operand regs cleared.
//  - FSM: IDLE -start-> CMP -> RES -> IDLE. In RES with start=1: recapture, go to CMP.
//  - Back-to-back throughput is one branch per 2 cycles.
//  - IDLE, start=1 at edge N: capture op/operands/pc_plus4/offset; state=CMP.
//  - CMP, edge N+1: register cond flag and target = pc_plus4 + (offset << OFF_SH).
//  - Target addition is modulo 2^DATA_W; wrap-around is silent, with no overflow flag.
//  - RES, edge N+2: done=1 for that cycle; taken and pc_next updated.
//  - done is a pulse, deasserted next cycle unless another RES follows.
//  - branch_op encoding; signed means two's complement over DATA_W:
//     0 beq  rs==rt        1 bne  rs!=rt
//     2 bgt  rs>rt  signed  3 ble  rs<=rt signed
//     4 blt  rs<rt  signed  5 bge  rs>=rt signed
//     6 bgtu rs>rt unsigned 7 bltu rs<rt unsigned
//  - All 8 codes are defined, so no illegal-op path exists.
//  - start while in CMP is ignored, with no queueing. Control must not pulse start then.
//  - Input changes after the capture edge have no effect on the in-flight branch.
//  - Reset asserted in CMP or RES aborts: next cycle IDLE, done=0, prior pc_next cleared to 0.
//  - busy = (state!=IDLE); purely decoded from the state register.
// CONFIGURATION
//  - BRANCH_STATS_EN defined: two CNT_W counters update on each done.
//    stat_total +1 always; stat_taken +1 when taken.
//    Both saturate at all-ones and do not wrap. Cleared only by reset.
//  - BRANCH_STATS_EN undefined: counters not instantiated; stat_total/stat_taken tied to 0.
//  - All other behaviour is identical in both builds.
// TESTING
//  - beq: rs=rt=0x5, pc_plus4=0x100, offset=0x3, start@N.
//    -> done@N+2, taken=1, pc_next=0x10C.
//  - ble signed: rs=0xFFFFFFFF(-1), rt=0x1 -> taken=1.
//    - Same operands with bltu -> taken=0, pc_next=pc_plus4.
//  - Wrap: pc_plus4=0xFFFFFFFC, offset=0x1, bne rs=1 rt=2 -> pc_next=0x00000000.
//  - Back-to-back: start in RES cycle with bgt rs=3 rt=2 -> second done exactly 2 cycles after the first.
//    - start held during CMP -> no extra done.
//  - Reset mid-op: start@N, reset@N+1 -> no done ever; busy=0, pc_next=0 at N+2.
//  - BRANCH_STATS_EN, CNT_W=2: 5 taken branches -> stat_total=3, stat_taken=3 (saturated).
//    - Without macro both read 0.

Source files
------------

// File: rtl/branch_resolve_if.sv
// Bus between the control unit and branch_resolve_unit.
// The control unit uses the master modport and the resolve unit uses the slave modport.
// stat_total/stat_taken carry live counts only when BRANCH_STATS_EN is defined; otherwise they read 0.
interface branch_resolve_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [2:0]        branch_op;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] offset;
  logic              busy;
  logic              done;
  logic              taken;
  logic [DATA_W-1:0] pc_next;
  logic [CNT_W-1:0]  stat_total;
  logic [CNT_W-1:0]  stat_taken;

  modport master (
    output start, branch_op, rs_val, rt_val, pc_plus4, offset,
    input  busy, done, taken, pc_next, stat_total, stat_taken
  );

  modport slave (
    input  start, branch_op, rs_val, rt_val, pc_plus4, offset,
    output busy, done, taken, pc_next, stat_total, stat_taken
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Registered branch-decision unit with a fixed 2-cycle latency: IDLE -> CMP -> RES.
// The control unit launches it with a start pulse. It produces pc_next and taken,
// and pulses done for one cycle when they are valid.
// Optional feature macro: BRANCH_STATS_EN adds saturating resolved/taken counters.
module branch_resolve_unit #(
  parameter int DATA_W = 32,
  parameter int OFF_SH = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  branch_resolve_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_RES  = 2'd2
  } state_e;

  state_e            state_q;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] rs_q;
  logic [DATA_W-1:0] rt_q;
  logic [DATA_W-1:0] pc4_q;
  logic [DATA_W-1:0] off_q;
  logic              cond_q;
  logic [DATA_W-1:0] target_q;
  logic              done_q;
  logic              taken_q;
  logic [DATA_W-1:0] pc_next_q;

  logic              cond_d;
  logic [DATA_W-1:0] target_d;

  // Condition evaluation and target computation on the captured operands; the target wraps modulo 2^DATA_W
  always_comb begin
    cond_d = 1'b0;
    case (op_q)
      3'd0: cond_d = (rs_q == rt_q);
      3'd1: cond_d = (rs_q != rt_q);
      3'd2: cond_d = ($signed(rs_q) >  $signed(rt_q));
      3'd3: cond_d = ($signed(rs_q) <= $signed(rt_q));
      3'd4: cond_d = ($signed(rs_q) <  $signed(rt_q));
      3'd5: cond_d = ($signed(rs_q) >= $signed(rt_q));
      3'd6: cond_d = (rs_q > rt_q);
      3'd7: cond_d = (rs_q < rt_q);
      default: cond_d = 1'b0;
    endcase
    target_d = pc4_q + (off_q << OFF_SH);
  end

  // Sequencing FSM: capture, evaluate, resolve; a start in RES recaptures so branches can issue every 2 cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      pc4_q     <= '0;
      off_q     <= '0;
      cond_q    <= 1'b0;
      target_q  <= '0;
      done_q    <= 1'b0;
      taken_q   <= 1'b0;
      pc_next_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            op_q    <= bus.branch_op;
            rs_q    <= bus.rs_val;
            rt_q    <= bus.rt_val;
            pc4_q   <= bus.pc_plus4;
            off_q   <= bus.offset;
            state_q <= S_CMP;
          end
        end
        S_CMP: begin
          cond_q   <= cond_d;
          target_q <= target_d;
          state_q  <= S_RES;
        end
        S_RES: begin
          done_q    <= 1'b1;
          taken_q   <= cond_q;
          pc_next_q <= cond_q ? target_q : pc4_q;
          if (bus.start) begin
            op_q    <= bus.branch_op;
            rs_q    <= bus.rs_val;
            rt_q    <= bus.rt_val;
            pc4_q   <= bus.pc_plus4;
            off_q   <= bus.offset;
            state_q <= S_CMP;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = done_q;
  assign bus.taken   = taken_q;
  assign bus.pc_next = pc_next_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] stat_total_q;
  logic [CNT_W-1:0] stat_taken_q;

  // Saturating counters advance on the same edge that raises done, so they line up with the result
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_total_q <= '0;
      stat_taken_q <= '0;
    end else if (state_q == S_RES) begin
      if (stat_total_q != '1) stat_total_q <= stat_total_q + 1'b1;
      if (cond_q && (stat_taken_q != '1)) stat_taken_q <= stat_taken_q + 1'b1;
    end
  end

  assign bus.stat_total = stat_total_q;
  assign bus.stat_taken = stat_taken_q;
`else
  assign bus.stat_total = '0;
  assign bus.stat_taken = '0;
`endif

endmodule
